// File: rtl/boot_axi_writer_pkg.sv
// Shared types and constants for the UART-to-AXI-Lite boot image writer.
package boot_axi_writer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StWaitWord,
        StXfer,
        StResp,
        StDone,
        StError
    } boot_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [3:0] WSTRB_ALL     = 4'hF;

endpackage

// File: rtl/boot_axi_writer_if.sv
// AXI-Lite write channel bundle driven by the boot writer.
interface boot_axi_writer_if;

    logic [31:0] boot_awaddr;
    logic        boot_awvalid;
    logic        boot_awready;
    logic [31:0] boot_wdata;
    logic        boot_wvalid;
    logic        boot_wready;
    logic [3:0]  boot_wstrb;
    logic        boot_bvalid;
    logic [1:0]  boot_bresp;
    logic        boot_bready;

    modport master (
        output boot_awaddr, boot_awvalid, boot_wdata, boot_wvalid, boot_wstrb, boot_bready,
        input  boot_awready, boot_wready, boot_bvalid, boot_bresp
    );

    modport slave (
        input  boot_awaddr, boot_awvalid, boot_wdata, boot_wvalid, boot_wstrb, boot_bready,
        output boot_awready, boot_wready, boot_bvalid, boot_bresp
    );

endinterface

// File: rtl/boot_byte_packer.sv
// Packs UART bytes little-endian into 32-bit words behind a one-word holding register.
module boot_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    input  logic        consume,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        overrun
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] word_q, word_d;
    logic        hold_valid_q, hold_valid_d;
    logic        overrun_q, overrun_d;

    always_comb begin
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        word_d       = word_q;
        hold_valid_d = hold_valid_q;
        overrun_d    = overrun_q;
        if (clear) begin
            cnt_d        = 2'd0;
            hold_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            if (consume) hold_valid_d = 1'b0;
            if (byte_en) begin
                cnt_d = cnt_q + 2'd1;
                unique case (cnt_q)
                    2'd0: asm_d[7:0]   = byte_data;
                    2'd1: asm_d[15:8]  = byte_data;
                    2'd2: asm_d[23:16] = byte_data;
                    2'd3: begin
                        // A word landing on a still-occupied slot is dropped, not queued.
                        if (hold_valid_q && !consume) begin
                            overrun_d = 1'b1;
                        end else begin
                            word_d       = {byte_data, asm_q};
                            hold_valid_d = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 2'd0;
            asm_q        <= 24'd0;
            word_q       <= 32'd0;
            hold_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            word_q       <= word_d;
            hold_valid_q <= hold_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign word       = word_q;
    assign word_valid = hold_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: rtl/boot_axi_writer.sv
// Boot loader: receives a length-prefixed word image over UART and writes it via AXI-Lite.
// Optional inter-byte timeout is built when BOOT_TIMEOUT_EN is defined.
module boot_axi_writer
    import boot_axi_writer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      boot_start,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    boot_axi_writer_if.master         bus,
    output logic                      boot_active,
    output logic                      boot_done,
    output logic                      boot_error
);

    boot_state_e state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] wdata_q, wdata_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic [31:0] word;
    logic        word_valid, overrun, consume, timeout;
    logic        start_ok, inflight, need_more, byte_en, aw_hs, w_hs;

    assign start_ok = boot_start && (state_q inside {StIdle, StDone, StError});
    assign inflight = state_q inside {StXfer, StResp};
    // Stop accepting bytes once every image word is held or in flight.
    assign need_more = (state_q == StLen) ||
                       ((state_q inside {StWaitWord, StXfer, StResp}) &&
                        (remaining_q > (32'(inflight) + 32'(word_valid))));
    assign byte_en  = rx_valid && !boot_start && need_more;
    assign aw_hs    = awvalid_q && bus.boot_awready;
    assign w_hs     = wvalid_q && bus.boot_wready;

    boot_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_en    (byte_en),
        .byte_data  (rx_data),
        .consume    (consume),
        .word       (word),
        .word_valid (word_valid),
        .overrun    (overrun)
    );

`ifdef BOOT_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (byte_en || word_valid || !(state_q inside {StLen, StWaitWord})) begin
            tmo_d = 32'd0;
        end else if (tmo_q != 32'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= 32'd0;
        else     tmo_q <= tmo_d;
    end

    assign timeout = (tmo_q == 32'(TIMEOUT_CYCLES)) && !word_valid;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        consume     = 1'b0;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_ok) state_d = StLen;
            end
            StLen: begin
                if (overrun || timeout) begin
                    state_d = StError;
                end else if (word_valid) begin
                    consume = 1'b1;
                    if (word == 32'd0) begin
                        state_d = StDone;
                    end else if (word > 32'(MAX_WORDS)) begin
                        state_d = StError;
                    end else begin
                        remaining_d = word;
                        addr_d      = BASE_ADDR;
                        state_d     = StWaitWord;
                    end
                end
            end
            StWaitWord: begin
                if (overrun || timeout) begin
                    state_d = StError;
                end else if (word_valid) begin
                    consume   = 1'b1;
                    wdata_d   = word;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StXfer;
                end
            end
            StXfer: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StResp;
            end
            StResp: begin
                if (bus.boot_bvalid) begin
                    if (bus.boot_bresp != AXI_RESP_OKAY) begin
                        state_d = StError;
                    end else begin
                        remaining_d = remaining_q - 32'd1;
                        addr_d      = addr_q + 32'd4;
                        if (remaining_q == 32'd1) state_d = StDone;
                        else if (overrun)         state_d = StError;
                        else                      state_d = StWaitWord;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= 32'd0;
            remaining_q <= 32'd0;
            wdata_q     <= 32'd0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    assign bus.boot_awaddr  = addr_q;
    assign bus.boot_awvalid = awvalid_q;
    assign bus.boot_wdata   = wdata_q;
    assign bus.boot_wvalid  = wvalid_q;
    assign bus.boot_wstrb   = WSTRB_ALL;
    assign bus.boot_bready  = (state_q == StResp);
    assign boot_active      = state_q inside {StLen, StWaitWord, StXfer, StResp};
    assign boot_done        = (state_q == StDone);
    assign boot_error       = (state_q == StError);

endmodule

// File: doc/boot_axi_writer.md
BOOT_AXI_WRITER -- requirements
Module: boot_axi_writer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, the first write address.
REQ-002 The block SHALL have parameter MAX_WORDS, default 16384, the largest accepted image length in words.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, the inter-byte timeout used only under BOOT_TIMEOUT_EN.
REQ-004 The block SHALL have the port list below.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- boot_start  in  1  single-cycle pulse that begins an image load.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  single-cycle byte strobe; there is no backpressure.
- boot_awaddr  out  32  AXI-Lite write address.
- boot_awvalid  out  1  AXI-Lite AW valid.
- boot_awready  in  1  AXI-Lite AW ready.
- boot_wdata  out  32  AXI-Lite write data.
- boot_wvalid  out  1  AXI-Lite W valid.
- boot_wready  in  1  AXI-Lite W ready.
- boot_wstrb  out  4  constant 4'hF.
- boot_bvalid  in  1  AXI-Lite B valid.
- boot_bresp  in  2  AXI-Lite B response.
- boot_bready  out  1  AXI-Lite B ready.
- boot_active  out  1  drives sel_bootloader of the master mux.
- boot_done  out  1  sticky flag: load completed.
- boot_error  out  1  sticky flag: load failed.

Function
REQ-005 The byte assembler SHALL pack four rx_valid bytes little-endian into one word: the first byte goes to [7:0]. On the fourth byte it SHALL load a one-word holding register and set hold_valid in the following cycle.
REQ-006 If a word completes while hold_valid=1, the block SHALL set a sticky overrun flag and discard the new word.
REQ-007 The FSM SHALL have the states IDLE, LEN, WAIT_WORD, XFER, RESP, DONE and ERROR.
REQ-008 boot_start SHALL be honoured only in IDLE, DONE or ERROR. It SHALL clear boot_done, boot_error, overrun, the byte counter and hold_valid, then enter LEN.
REQ-009 In LEN, the first held word SHALL be consumed as the length N.
- N=0: go to DONE.
- N>MAX_WORDS: go to ERROR.
- Otherwise: go to WAIT_WORD with remaining=N and addr=BASE_ADDR.
REQ-010 In WAIT_WORD with hold_valid=1, the block SHALL consume the held word, set boot_awvalid=boot_wvalid=1 with boot_awaddr=addr, and enter XFER.
REQ-011 In XFER, each of boot_awvalid and boot_wvalid SHALL drop the cycle after its own handshake. AW and W may complete in either order or together. Address and data SHALL stay stable while their valid is high.
REQ-012 When both handshakes are done, the block SHALL enter RESP with boot_bready=1.
REQ-013 When boot_bvalid=1 in RESP:
- boot_bresp!=2'b00: go to ERROR.
- Otherwise decrement remaining and add 4 to addr (mod 2^32).
- Then go to DONE if remaining==0; else go to ERROR if overrun=1; else go to WAIT_WORD.
REQ-014 Overrun detected in LEN or WAIT_WORD SHALL move the FSM to ERROR on the next cycle. Overrun detected in XFER or RESP SHALL be acted on only after the B handshake, so no transaction is abandoned.
REQ-015 boot_active SHALL be 1 in LEN, WAIT_WORD, XFER and RESP, and 0 in IDLE, DONE and ERROR. It SHALL therefore never drop with a transaction outstanding.
REQ-016 boot_done SHALL be 1 in DONE and boot_error SHALL be 1 in ERROR; both hold until the next boot_start.
REQ-017 Bytes received in IDLE, DONE or ERROR SHALL be ignored.
REQ-018 A byte arriving in the same cycle as boot_start SHALL be ignored.
REQ-019 Bytes arriving after the N-th word SHALL be ignored.

Reset
REQ-020 On rst=1, the block SHALL asynchronously clear all outputs to 0 except boot_wstrb, and place the FSM in IDLE.
REQ-021 On rst=1, the block SHALL clear addr, remaining, the byte counter, the holding register, hold_valid and overrun.
REQ-022 rst asserted mid-transaction SHALL drop the valids immediately; recovering the interconnect is a system-level duty.

Configuration
REQ-023 The macro BOOT_TIMEOUT_EN SHALL control the inter-byte timeout.
- Defined: a counter clears on every accepted byte and on entry to LEN. If it reaches TIMEOUT_CYCLES in LEN or WAIT_WORD with hold_valid=0, the FSM SHALL enter ERROR.
- Undefined: no counter exists, and the block waits indefinitely for bytes.

Structure
REQ-024 A shared package SHALL hold the FSM state enumeration, the constant AXI_RESP_OKAY=2'b00 and the constant WSTRB_ALL=4'hF.
REQ-025 The byte assembler and holding register SHALL be one sub-module, boot_byte_packer, with outputs word[31:0], word_valid and overrun.

Verification
REQ-026 The bench SHALL cover the following directed scenarios.
- Nominal load: start, then bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE, with the slave always ready and OKAY -> writes 0x12345678 @0x0 and 0xDEADBEEF @0x4, then boot_done=1 and boot_active=0.
- Zero length: N=0 -> DONE with no AW/W activity.
- Over limit: N=MAX_WORDS+1 -> ERROR with no AW/W activity.
- Late W handshake: boot_awready=1 immediately, boot_wready delayed 5 cycles -> awvalid drops first, exactly one B is accepted, and addr advances by 4.
- Slave error: boot_bresp=2'b10 on word 1 of 3 -> ERROR after the B handshake, with no further writes.
- Overrun: boot_bvalid stalled for 40 cycles while 8 bytes stream at 1 byte every 4 cycles -> ERROR after the B handshake; under BOOT_TIMEOUT_EN, stopping the bytes mid-word -> ERROR after TIMEOUT_CYCLES.
